// File: rtl/spi_master_ctrl.sv
// SPI master transfer controller (mode 0, MSB first).
// Controls chip select and the SCLK divider enable. It shifts tx_data_i out on
// mosi_o and collects miso_i into rx_data_o. Edge timing comes from an
// external divider through pos_edge_i and neg_edge_i.
//
// Ports:
//   clk_10MHz  - sole clock, rising edge
//   rst_i      - synchronous active-high reset
//   start_i    - transfer request, sampled in IDLE only
//   tx_data_i  - word to send, captured when start_i is accepted
//   rx_data_o  - last received word, updated when the transfer completes
//   busy_o     - high whenever the controller is not IDLE
//   done_o     - one-cycle completion strobe
//   en_sclk_o  - enable to the SCLK divider
//   pos_edge_i - divider strobe: SCLK rising edge
//   neg_edge_i - divider strobe: SCLK falling edge
//   cs_n_o     - chip select, active low
//   mosi_o     - serial data out (MSB of tx shift register)
//   miso_i     - serial data in, already synchronous to clk_10MHz
module spi_master_ctrl #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CS_SETUP = 50,
  parameter int unsigned CS_HOLD  = 50
) (
  input  logic              clk_10MHz,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              en_sclk_o,
  input  logic              pos_edge_i,
  input  logic              neg_edge_i,
  output logic              cs_n_o,
  output logic              mosi_o,
  input  logic              miso_i
);

  localparam int unsigned DLY_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

  localparam logic [DLY_W-1:0] SETUP_LAST = DLY_W'(CS_SETUP - 1);
  localparam logic [DLY_W-1:0] HOLD_LAST  = DLY_W'(CS_HOLD - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] tx_sr, tx_sr_nxt;
  logic [DATA_W-1:0] rx_sr, rx_sr_nxt;
  logic [DATA_W-1:0] rx_data, rx_data_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DLY_W-1:0]  dly_cnt, dly_cnt_nxt;
  logic              cs_n, cs_n_nxt;
  logic              en_sclk, en_sclk_nxt;

  always_ff @(posedge clk_10MHz) begin
    if (rst_i) begin
      state   <= S_IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      dly_cnt <= '0;
      cs_n    <= 1'b1;
      en_sclk <= 1'b0;
    end else begin
      state   <= state_nxt;
      tx_sr   <= tx_sr_nxt;
      rx_sr   <= rx_sr_nxt;
      rx_data <= rx_data_nxt;
      bit_cnt <= bit_cnt_nxt;
      dly_cnt <= dly_cnt_nxt;
      cs_n    <= cs_n_nxt;
      en_sclk <= en_sclk_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tx_sr_nxt   = tx_sr;
    rx_sr_nxt   = rx_sr;
    rx_data_nxt = rx_data;
    bit_cnt_nxt = bit_cnt;
    dly_cnt_nxt = dly_cnt;
    cs_n_nxt    = cs_n;
    en_sclk_nxt = en_sclk;

    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          tx_sr_nxt   = tx_data_i;
          bit_cnt_nxt = '0;
          dly_cnt_nxt = '0;
          cs_n_nxt    = 1'b0;
          state_nxt   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (dly_cnt == SETUP_LAST) begin
          en_sclk_nxt = 1'b1;
          dly_cnt_nxt = '0;
          state_nxt   = S_SHIFT;
        end else begin
          dly_cnt_nxt = dly_cnt + 1'b1;
        end
      end
      S_SHIFT: begin
        // A coincident falling strobe is dropped; the rising-edge sample wins.
        if (pos_edge_i) begin
          rx_sr_nxt   = {rx_sr[DATA_W-2:0], miso_i};
          bit_cnt_nxt = bit_cnt + 1'b1;
        end else if (neg_edge_i) begin
          // The falling edge after the last sample ends the burst with
          // SCLK low, so no shift is needed on it.
          if (bit_cnt == BIT_LAST) begin
            en_sclk_nxt = 1'b0;
            dly_cnt_nxt = '0;
            state_nxt   = S_HOLD;
          end else begin
            tx_sr_nxt = {tx_sr[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_HOLD: begin
        if (dly_cnt == HOLD_LAST) begin
          cs_n_nxt    = 1'b1;
          rx_data_nxt = rx_sr;
          dly_cnt_nxt = '0;
          state_nxt   = S_DONE;
        end else begin
          dly_cnt_nxt = dly_cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign rx_data_o = rx_data;
  assign busy_o    = (state != S_IDLE);
  assign done_o    = (state == S_DONE);
  assign en_sclk_o = en_sclk;
  assign cs_n_o    = cs_n;
  assign mosi_o    = tx_sr[DATA_W-1];

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl.
// The bench contains a behavioural 10MHz->100kHz SCLK divider and a MISO
// source. The source either loops MOSI back or plays a fixed pattern word
// MSB first. Expected words are queued when a transfer is issued. A monitor
// pops them on each done_o and checks rx_data_o against them. It also checks
// the MOSI bits seen at SCLK rising edges and the CS setup/hold spacing.
module tb_spi_master_ctrl;

  localparam int DW = 8;
  localparam int SU = 50;
  localparam int HD = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] rx_data;
  logic          busy, done, en_sclk, cs_n, mosi, miso;
  logic          pos_edge = 1'b0;
  logic          neg_edge = 1'b0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.DATA_W(DW), .CS_SETUP(SU), .CS_HOLD(HD)) dut (
    .clk_10MHz (clk),
    .rst_i     (rst),
    .start_i   (start),
    .tx_data_i (tx_data),
    .rx_data_o (rx_data),
    .busy_o    (busy),
    .done_o    (done),
    .en_sclk_o (en_sclk),
    .pos_edge_i(pos_edge),
    .neg_edge_i(neg_edge),
    .cs_n_o    (cs_n),
    .mosi_o    (mosi),
    .miso_i    (miso)
  );

  // SCLK divider: toggles every 50 clk cycles while enabled, held low and cleared otherwise.
  logic sclk = 1'b0;
  int   dcnt = 0;
  int   rises = 0;
  always @(posedge clk) begin
    if (!en_sclk) begin
      sclk     <= 1'b0;
      dcnt     <= 0;
      rises    <= 0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
    end else begin
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
      if (dcnt == 49) begin
        dcnt <= 0;
        sclk <= ~sclk;
        if (!sclk) begin
          pos_edge <= 1'b1;
          rises    <= rises + 1;
        end else begin
          neg_edge <= 1'b1;
        end
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  // MISO source: loopback, or pattern bit for the k-th rising edge (MSB first).
  logic          loopback = 1'b1;
  logic [DW-1:0] pat = '0;
  assign miso = loopback ? mosi :
                ((rises >= 1 && rises <= DW) ? pat[DW - rises] : 1'b0);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_rx[$];
  logic [DW-1:0] exp_tx[$];
  int            exp_done = 0;
  int            n_done   = 0;
  logic          in_reset = 1'b1;

  // Monitor / scoreboard
  initial begin
    int            cyc = 0;
    int            t_cs = 0;
    int            t_en = 0;
    bit            cs_fall_ok = 0;
    bit            en_fall_ok = 0;
    logic          prev_cs = 1'b1;
    logic          prev_en = 1'b0;
    logic [DW-1:0] cap = '0;
    int            cap_n = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (in_reset) begin
        cs_fall_ok = 0;
        en_fall_ok = 0;
      end else begin
        if (prev_cs && !cs_n) begin
          cap        = '0;
          cap_n      = 0;
          t_cs       = cyc;
          cs_fall_ok = 1;
        end
        if (pos_edge && en_sclk) begin
          cap = {cap[DW-2:0], mosi};
          cap_n++;
        end
        if (!prev_en && en_sclk && cs_fall_ok) begin
          chk("cs_setup_cycles", cyc - t_cs, SU);
          cs_fall_ok = 0;
        end
        if (prev_en && !en_sclk) begin
          t_en       = cyc;
          en_fall_ok = 1;
        end
        if (!prev_cs && cs_n && en_fall_ok) begin
          chk("cs_hold_cycles", cyc - t_en, HD);
          en_fall_ok = 0;
        end
        if (done) begin
          n_done++;
          if (exp_rx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: actual=done_o pulse required=none");
          end else begin
            chk("rx_data", rx_data, exp_rx.pop_front());
            chk("mosi_bits", cap, exp_tx.pop_front());
            chk("sclk_rises", cap_n, DW);
            chk("busy_in_done", busy, 1);
          end
        end
      end
      prev_cs = cs_n;
      prev_en = en_sclk;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: actual=busy required=idle within 3000 cycles");
    end
  endtask

  task automatic xfer(input logic [DW-1:0] tx, input logic lb, input logic [DW-1:0] p,
                      input bit wait_end);
    wait_idle();
    loopback = lb;
    pat      = p;
    tx_data  = tx;
    start    = 1'b1;
    exp_rx.push_back(lb ? tx : p);
    exp_tx.push_back(tx);
    exp_done++;
    @(negedge clk);
    start   = 1'b0;
    tx_data = DW'($urandom);
    chk("busy_after_start", busy, 1);
    if (wait_end) wait_idle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cs_n"}, cs_n, 1);
    chk({tag, "_en_sclk"}, en_sclk, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mosi"}, mosi, 0);
    chk({tag, "_rx_data"}, rx_data, 0);
  endtask

  initial begin
    int n;
    int cnt;
    int dones;
    int gap;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;

    // Loopback 0xA5, then MISO tied high with tx 0x00.
    xfer(8'hA5, 1'b1, 8'h00, 1);
    xfer(8'h00, 1'b0, 8'hFF, 1);

    // Start pulse 100 cycles into SHIFT must be ignored.
    xfer(8'h96, 1'b1, 8'h00, 0);
    n = 0;
    while (!en_sclk && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("en_sclk_rose", en_sclk, 1);
    repeat (100) @(negedge clk);
    tx_data = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("no_queued_start", busy, 0);

    // Reset after the 4th rising-edge strobe aborts the transfer.
    xfer(8'h5A, 1'b1, 8'h00, 0);
    cnt = 0;
    n   = 0;
    while (cnt < 4 && n < 2000) begin
      @(negedge clk);
      n++;
      if (pos_edge && en_sclk) cnt++;
    end
    chk("pos_edges_before_abort", cnt, 4);
    @(negedge clk);
    in_reset = 1'b1;
    rst      = 1'b1;
    void'(exp_rx.pop_back());
    void'(exp_tx.pop_back());
    exp_done--;
    @(negedge clk);
    chk_reset_state("abort");
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;
    xfer(8'h3C, 1'b1, 8'h00, 1);

    // start_i held high across three transfers of 0x81.
    loopback = 1'b1;
    tx_data  = 8'h81;
    start    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_rx.push_back(8'h81);
      exp_tx.push_back(8'h81);
      exp_done++;
    end
    dones = 0;
    gap   = 0;
    n     = 0;
    while (dones < 3 && n < 5000) begin
      @(negedge clk);
      n++;
      if (done) begin
        dones++;
        chk("cs_high_in_done", cs_n, 1);
        if (dones == 3) start = 1'b0;
      end
      if (!busy) gap++;
      else if (gap > 0) begin
        chk("busy_gap_cycles", gap, 1);
        gap = 0;
      end
    end
    chk("held_start_dones", dones, 3);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("no_fourth_transfer", busy, 0);

    // Randomized transfers.
    for (int i = 0; i < 6; i++) begin
      logic [DW-1:0] t;
      logic [DW-1:0] p;
      logic          lb;
      t  = DW'($urandom);
      p  = DW'($urandom);
      lb = 1'($urandom_range(0, 1));
      xfer(t, lb, p, 1);
    end

    repeat (5) @(negedge clk);
    chk("done_count", n_done, exp_done);
    chk("scoreboard_empty", exp_rx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
